// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue between decode and execute.
// Replays the oldest entry on the predictor update bus when EX resolves it.
module branch_resolve_queue #(
  parameter int HISTORY_SIZE = 10,
  parameter int COUNT_SIZE   = 10,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [HISTORY_SIZE-1:0] push_pc_i,
  input  logic [1:0]              push_predictor_i,
  input  logic [COUNT_SIZE-1:0]   push_pattern_i,
  input  logic                    resolve_i,
  input  logic                    taken_i,
  input  logic                    flush_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DEPTH_LOG2:0]     count_o,
  output logic                    EX_is_Branch_o,
  output logic                    branch_o,
  output logic [HISTORY_SIZE-1:0] write_Branch_PC_o,
  output logic [1:0]              old_predictor_o,
  output logic [COUNT_SIZE-1:0]   old_pattern_o,
  output logic                    mispredict_o,
  output logic [31:0]             branches_o,
  output logic [31:0]             mispredicts_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [HISTORY_SIZE-1:0] pc_mem_q   [DEPTH];
  logic [1:0]              pred_mem_q [DEPTH];
  logic [COUNT_SIZE-1:0]   pat_mem_q  [DEPTH];

  logic                    vld_q, br_q, mis_q;
  logic [HISTORY_SIZE-1:0] pc_q;
  logic [1:0]              pred_q;
  logic [COUNT_SIZE-1:0]   pat_q;
  logic [31:0]             branches_q, mispredicts_q;

  logic [DEPTH_LOG2-1:0]   rd_idx, wr_idx;
  logic                    push_ok, pop_ok, mis, squash, wr_en;

  assign rd_idx  = rd_ptr_q[DEPTH_LOG2-1:0];
  assign wr_idx  = wr_ptr_q[DEPTH_LOG2-1:0];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_idx == rd_idx);

  // Full is judged before any same-cycle pop, so a push into a full queue is lost.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = resolve_i && !empty_o;
  assign mis     = pop_ok && (taken_i ^ pred_mem_q[rd_idx][1]);
  assign squash  = mis || flush_i;
  assign wr_en   = push_ok && !squash;

  always_comb begin
    rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
    wr_ptr_d = wr_ptr_q;
    if (squash)
      wr_ptr_d = rd_ptr_d;
    else if (push_ok)
      wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem_q[wr_idx]   <= push_pc_i;
      pred_mem_q[wr_idx] <= push_predictor_i;
      pat_mem_q[wr_idx]  <= push_pattern_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Update bus: one-cycle pulse after an accepted resolve, zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i || !pop_ok) begin
      vld_q  <= 1'b0;
      br_q   <= 1'b0;
      pc_q   <= '0;
      pred_q <= '0;
      pat_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      vld_q  <= 1'b1;
      br_q   <= taken_i;
      pc_q   <= pc_mem_q[rd_idx];
      pred_q <= pred_mem_q[rd_idx];
      pat_q  <= pat_mem_q[rd_idx];
      mis_q  <= mis;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (pop_ok) branches_q    <= branches_q + 32'd1;
      if (mis)    mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign EX_is_Branch_o    = vld_q;
  assign branch_o          = br_q;
  assign write_Branch_PC_o = pc_q;
  assign old_predictor_o   = pred_q;
  assign old_pattern_o     = pat_q;
  assign mispredict_o      = mis_q;
  assign branches_o        = branches_q;
  assign mispredicts_o     = mispredicts_q;
endmodule
